// File: rtl/aes_block_fifo.sv
// aes_block_fifo: packs 32-bit words into 128-bit blocks (first word in the
// most significant lane) and queues completed blocks for the select stage.
module aes_block_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_flush,
  input  logic                     i_word_valid,
  input  logic [31:0]              i_word,
  output logic                     o_word_ready,
  input  logic                     i_pop,
  output logic                     o_read_fifo,
  output logic [127:0]             o_fifo_out,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [127:0]     mem [DEPTH];
  logic [127:0]     pack_p0;
  logic [1:0]       word_cnt;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic accept;
  logic push;
  logic pop;

  // Handshake decode; ready depends only on registered state so the
  // upstream path never sees a combinational loop through i_pop.
  always_comb begin
    o_word_ready = !((word_cnt == 2'd3) && o_full);
    accept       = i_word_valid && o_word_ready;
    push         = accept && (word_cnt == 2'd3);
    pop          = i_pop && o_read_fifo;
  end

  // Control state: pointers, occupancy, word counter and the partial block.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      word_cnt <= 2'd0;
      pack_p0  <= '0;
    end else begin
      if (accept) begin
        word_cnt <= word_cnt + 2'd1;
        case (word_cnt)
          2'd0:    pack_p0[127:96] <= i_word;
          2'd1:    pack_p0[95:64]  <= i_word;
          2'd2:    pack_p0[63:32]  <= i_word;
          default: ;
        endcase
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Block storage is unreset; only pointers and count decide what is visible.
  always_ff @(posedge i_clk) begin
    if (!i_reset && !i_flush && push)
      mem[wr_ptr] <= {pack_p0[127:32], i_word};
  end

  // Status and head-of-queue outputs; an empty queue presents zeros.
  always_comb begin
    o_count     = count;
    o_read_fifo = (count != '0);
    o_full      = (count == CNT_W'(DEPTH));
    o_fifo_out  = o_read_fifo ? mem[rd_ptr] : 128'h0;
  end

endmodule
